lcd_scanout: RTL
================

Name: lcd_scanout

Overview:
- Frame-buffer scanout stage feeding the LCD pixel pipeline.
- Fetches RGB888 pixels from a burst memory read port into an internal FIFO.
- Pops one pixel per LCD tick while the timing generator asserts data_enable, and drives registered red/green/blue to the output colour latches and GPIO mapping.
- Restarts each frame from a latched base address on the timing generator's next_frame pulse.

Parameters:
- H_ACTIVE, 800, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- ADDR_WIDTH, 24, memory word address width.
- BURST_LEN, 32, words per read burst; H_ACTIVE*V_ACTIVE must be a multiple of it.
- FIFO_LOG2, 8, log2 of FIFO depth (256 words); depth must be at least 2*BURST_LEN.

Ports:
- clock  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  LCD pixel enable, one clock wide, every other clock.
- data_enable  in  1  active-area flag from the timing generator; sampled only when tick=1.
- next_frame  in  1  one-clock pulse at the start of vertical blank.
- frame_base  in  ADDR_WIDTH  word address of pixel (0,0); sampled on next_frame.
- mem_read  out  1  burst request, held until accepted.
- mem_address  out  ADDR_WIDTH  burst start word address, stable while mem_read=1.
- mem_ack  in  1  request accepted in the cycle where mem_read and mem_ack are both 1.
- mem_data_valid  in  1  one returned word this cycle.
- mem_data  in  32  returned word; [23:16]=R, [15:8]=G, [7:0]=B, [31:24] ignored.
- red  out  8  pixel red.
- green  out  8  pixel green.
- blue  out  8  pixel blue.
- underflow  out  1  sticky flag: a pixel was needed while the FIFO was empty.

Behaviour:
- Reset state: mem_read=0, mem_address=0, red=green=blue=0, underflow=0, FIFO empty, fetch state IDLE, words_fetched=0. Reset may assert mid-burst; all state clears immediately.
- Fetch FSM states:
  - IDLE: waits for next_frame.
  - ISSUE: mem_read=1 until mem_ack.
  - RECEIVE: counts BURST_LEN mem_data_valid words.
  - DONE: whole frame fetched, waits for next_frame.
- Transitions:
  - IDLE --next_frame--> ISSUE.
  - ISSUE --mem_ack--> RECEIVE. mem_address advances by BURST_LEN after the ack.
  - RECEIVE --last word--> ISSUE if words_fetched < H_ACTIVE*V_ACTIVE and free space >= BURST_LEN. Otherwise it holds in RECEIVE-complete/wait until space is available, or goes to DONE when the frame is complete.
  - DONE --next_frame--> ISSUE.
- Space rule: a request issues only if FIFO free slots >= BURST_LEN at the issue cycle. Every acked burst therefore always fits, and no overflow is possible.
- On next_frame:
  - frame_base is latched into mem_address.
  - words_fetched=0.
  - The FIFO is flushed in the same cycle. A simultaneous pop is ignored and the flush wins.
- next_frame during RECEIVE: the remaining words of the outstanding burst are absorbed and discarded (not written), then the FSM goes to ISSUE at the new base.
- next_frame during ISSUE before ack: the request is retargeted. mem_address changes to frame_base only after mem_read drops for one cycle (no address change while a request is pending).
- Pop: occurs when tick=1 and data_enable=1.
  - FIFO non-empty: the head word loads into red/green/blue at the next clock edge (1-clock latency).
  - FIFO empty: red/green/blue load 0 and underflow sets. underflow clears only on reset.
- When tick=1 and data_enable=0, red/green/blue load 0 (blanking). When tick=0, outputs hold.
- Simultaneous write (mem_data_valid) and pop on the same cycle are both performed; occupancy is unchanged.
- Pointers are FIFO_LOG2+1 bits, so the wrap bit distinguishes full from empty. Occupancy = wr_ptr - rd_ptr, modulo 2^(FIFO_LOG2+1).
- mem_address wraps modulo 2^ADDR_WIDTH.

Test Plan:
- Basic fill: reset, next_frame with frame_base=0x001000, memory acks after 3 cycles and returns 32 words with value = address.
  -> First request at 0x001000, second at 0x001020, eight bursts outstanding-free until the FIFO holds 256 words, then mem_read=0.
- Pixel order: after fill, drive 800 tick+data_enable pops.
  -> Outputs {R,G,B} follow mem_data[23:0] in address order, one clock after each pop tick, underflow=0.
- Underflow: memory never returns data, then one pop tick.
  -> Outputs 0x00/0x00/0x00 and underflow=1, staying 1 through a later next_frame.
- Mid-burst frame restart: next_frame asserted after 10 of 32 words, frame_base=0x200000.
  -> 22 remaining words discarded, FIFO empty, next request at 0x200000.
- Full frame: 384000 words fetched.
  -> Exactly 12000 acks, FSM in DONE, mem_read=0 until next_frame.
- Async reset mid-RECEIVE: reset pulse between clock edges.
  -> mem_read=0, outputs 0, FIFO empty immediately without waiting for a clock edge.

Source files
------------

// File: rtl/lcd_scanout.sv
// lcd_scanout: frame-buffer scanout stage for the LCD pixel pipeline.
// Fetches RGB888 words from a burst read port into a FIFO and pops one
// pixel per LCD tick while data_enable is high. Each frame restarts from
// frame_base, which is latched on next_frame.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   tick, data_enable   pixel enable and active-area flag from the timing generator
//   next_frame          start-of-vblank pulse; frame_base is sampled with it
//   mem_read/_address   burst request and start word address (held until mem_ack)
//   mem_ack             request accepted while mem_read=1
//   mem_data_valid/data returned words, [23:16]=R [15:8]=G [7:0]=B
//   red, green, blue    registered pixel output
//   underflow           sticky: a pixel was needed while the FIFO was empty
module lcd_scanout #(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_WIDTH = 24,
  parameter int BURST_LEN  = 32,
  parameter int FIFO_LOG2  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  data_enable,
  input  logic                  next_frame,
  input  logic [ADDR_WIDTH-1:0] frame_base,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_ack,
  input  logic                  mem_data_valid,
  input  logic [31:0]           mem_data,
  output logic [7:0]            red,
  output logic [7:0]            green,
  output logic [7:0]            blue,
  output logic                  underflow
);

  localparam int TOTAL_WORDS = H_ACTIVE * V_ACTIVE;
  localparam int DEPTH       = 1 << FIFO_LOG2;
  localparam int PTR_W       = FIFO_LOG2 + 1;
  localparam int WF_W        = $clog2(TOTAL_WORDS + 1);
  localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [WF_W-1:0]       TOTAL_C   = WF_W'(TOTAL_WORDS);
  localparam logic [PTR_W-1:0]      DEPTH_P   = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0]      BURST_P   = PTR_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BURST_LEN);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RETARGET,
    RECEIVE,
    WAIT_SPACE,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rt_base_q, rt_base_d;
  logic [WF_W-1:0]       wf_q, wf_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  discard_q, discard_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [23:0]           pix_q, pix_d;
  logic                  underflow_q, underflow_d;

  logic [23:0]      fifo_mem [DEPTH];
  logic [PTR_W-1:0] occ_q, occ_d, free_d;
  logic             fifo_empty, wr_en, rd_en;
  logic             unused_hi;

  assign unused_hi = ^mem_data[31:24];

  // FIFO datapath and pixel register; next_frame flushes and suppresses any pop
  always_comb begin
    occ_q      = wr_ptr_q - rd_ptr_q;
    fifo_empty = (occ_q == '0);
    wr_en      = (state_q == RECEIVE) && mem_data_valid && !discard_q && !next_frame;
    rd_en      = tick && data_enable && !next_frame && !fifo_empty;
    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d   = rd_ptr_q + PTR_W'(rd_en);
    if (next_frame) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    occ_d  = wr_ptr_d - rd_ptr_d;
    free_d = DEPTH_P - occ_d;

    pix_d       = pix_q;
    underflow_d = underflow_q;
    if (tick) begin
      if (!data_enable) begin
        pix_d = '0;
      end else if (!next_frame) begin
        if (fifo_empty) begin
          pix_d       = '0;
          underflow_d = 1'b1;
        end else begin
          pix_d = fifo_mem[rd_ptr_q[FIFO_LOG2-1:0]];
        end
      end
    end
  end

  // Fetch FSM. Space is judged on post-update occupancy so the last word of
  // a burst and a same-cycle pop are both accounted for.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rt_base_d = rt_base_q;
    beat_d    = beat_q;
    discard_d = discard_q;
    wf_d      = next_frame ? '0 : (wf_q + WF_W'(wr_en));
    mem_read  = (state_q == ISSUE);

    case (state_q)
      IDLE, DONE, WAIT_SPACE: begin
        if (next_frame) begin
          addr_d  = frame_base;
          state_d = ISSUE;
        end else if (state_q == WAIT_SPACE && free_d >= BURST_P) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          beat_d  = '0;
          state_d = RECEIVE;
          if (next_frame) begin
            // burst accepted at the old address: absorb it entirely
            discard_d = 1'b1;
            addr_d    = frame_base;
          end else begin
            discard_d = 1'b0;
            addr_d    = addr_q + ADDR_STEP;
          end
        end else if (next_frame) begin
          // drop mem_read for one cycle before moving the address
          rt_base_d = frame_base;
          state_d   = RETARGET;
        end
      end
      RETARGET: begin
        addr_d  = next_frame ? frame_base : rt_base_q;
        state_d = ISSUE;
      end
      RECEIVE: begin
        if (next_frame) begin
          addr_d = frame_base;
        end
        if (mem_data_valid) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_LAST) begin
            discard_d = 1'b0;
            if (wf_d == TOTAL_C) begin
              state_d = DONE;
            end else if (free_d >= BURST_P) begin
              state_d = ISSUE;
            end else begin
              state_d = WAIT_SPACE;
            end
          end else if (next_frame) begin
            discard_d = 1'b1;
          end
        end else if (next_frame) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rt_base_q   <= '0;
      wf_q        <= '0;
      beat_q      <= '0;
      discard_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pix_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rt_base_q   <= rt_base_d;
      wf_q        <= wf_d;
      beat_q      <= beat_d;
      discard_q   <= discard_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pix_q       <= pix_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_q[FIFO_LOG2-1:0]] <= mem_data[23:0];
    end
  end

  assign mem_address = addr_q;
  assign red         = pix_q[23:16];
  assign green       = pix_q[15:8];
  assign blue        = pix_q[7:0];
  assign underflow   = underflow_q;

endmodule
